leds_wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter that shares the LED peripheral between the ARM host bridge (master 0) and an on-fabric pattern engine (master 1).
- Round-robin grant, held for the whole bus cycle (cyc).
- Per-transfer ack watchdog returns an error pulse to the master and frees the bus if the slave never acknowledges.
- Sits between the masters and the LED peripheral's Wishbone slave port.

---
 rtl/leds_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_leds_wb_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/leds_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the LED slave.
// Grant is held for a whole bus cycle; a watchdog aborts transfers the slave never acknowledges.
module leds_wb_arbiter #(
   parameter int ADDR_WIDTH     = 1,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] m0_address,
   input  logic [DATA_WIDTH-1:0] m0_writedata,
   output logic [DATA_WIDTH-1:0] m0_readdata,
   input  logic                  m0_strobe,
   input  logic                  m0_write,
   input  logic                  m0_cycle,
   output logic                  m0_ack,
   output logic                  m0_err,
   input  logic [ADDR_WIDTH-1:0] m1_address,
   input  logic [DATA_WIDTH-1:0] m1_writedata,
   output logic [DATA_WIDTH-1:0] m1_readdata,
   input  logic                  m1_strobe,
   input  logic                  m1_write,
   input  logic                  m1_cycle,
   output logic                  m1_ack,
   output logic                  m1_err,
   output logic [ADDR_WIDTH-1:0] s_address,
   output logic [DATA_WIDTH-1:0] s_writedata,
   input  logic [DATA_WIDTH-1:0] s_readdata,
   output logic                  s_strobe,
   output logic                  s_write,
   output logic                  s_cycle,
   input  logic                  s_ack,
   output logic [1:0]            grant
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   localparam logic [15:0] TIMEOUT_VALUE = 16'(TIMEOUT_CYCLES);

   state_t                state;
   state_t                state_next;
   logic                  last_owner;
   logic                  last_owner_next;
   logic [15:0]           wd_count;
   logic [15:0]           wd_count_next;

   logic                  owning;
   logic                  owner_sel;
   logic                  owner_cycle;
   logic                  owner_strobe;
   logic                  owner_write;
   logic [ADDR_WIDTH-1:0] owner_address;
   logic [DATA_WIDTH-1:0] owner_writedata;
   logic                  timeout;

   // The owner's bus signals, selected once and shared by the next-state and output logic.
   always_comb begin
      owning          = (state != IDLE);
      owner_sel       = (state == OWN1);
      owner_cycle     = owner_sel ? m1_cycle     : m0_cycle;
      owner_strobe    = owner_sel ? m1_strobe    : m0_strobe;
      owner_write     = owner_sel ? m1_write     : m0_write;
      owner_address   = owner_sel ? m1_address   : m0_address;
      owner_writedata = owner_sel ? m1_writedata : m0_writedata;
      // A late ack in the very cycle the limit is reached still counts as a good transfer.
      timeout         = owning && (wd_count == TIMEOUT_VALUE) && !s_ack;
   end

   // Arbitration and watchdog counting; the counter only survives a cycle of stalled strobe.
   always_comb begin
      state_next      = state;
      last_owner_next = last_owner;
      wd_count_next   = '0;
      case (state)
         IDLE: begin
            if (m0_cycle && m1_cycle) begin
               state_next = last_owner ? OWN0 : OWN1;
            end else if (m0_cycle) begin
               state_next = OWN0;
            end else if (m1_cycle) begin
               state_next = OWN1;
            end
         end
         OWN0, OWN1: begin
            if (timeout || !owner_cycle) begin
               state_next      = IDLE;
               last_owner_next = owner_sel;
            end else if (owner_strobe && !s_ack) begin
               wd_count_next = wd_count + 16'd1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Master 0 is favoured on the first tie after reset by pretending master 1 went last.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         wd_count   <= '0;
      end else begin
         state      <= state_next;
         last_owner <= last_owner_next;
         wd_count   <= wd_count_next;
      end
   end

   // Slave side sees only the owner; an asserted reset silences every handshake immediately.
   always_comb begin
      m0_readdata = s_readdata;
      m1_readdata = s_readdata;
      s_address   = '0;
      s_writedata = '0;
      s_strobe    = 1'b0;
      s_write     = 1'b0;
      s_cycle     = 1'b0;
      m0_ack      = 1'b0;
      m0_err      = 1'b0;
      m1_ack      = 1'b0;
      m1_err      = 1'b0;
      grant       = 2'b00;
      if (owning && !reset) begin
         s_address   = owner_address;
         s_writedata = owner_writedata;
         s_write     = owner_write;
         s_strobe    = owner_strobe && !timeout;
         s_cycle     = owner_cycle && !timeout;
         if (owner_sel) begin
            grant  = 2'b10;
            m1_ack = s_ack;
            m1_err = timeout;
         end else begin
            grant  = 2'b01;
            m0_ack = s_ack;
            m0_err = timeout;
         end
      end
   end

endmodule

// File: tb/tb_leds_wb_arbiter.sv
// Bench for leds_wb_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against an owner/last-owner/wait-count model of the arbiter.
module tb_leds_wb_arbiter;

   localparam int TMO = 4;

   logic        clk;
   logic        reset;
   logic [0:0]  m_address   [2];
   logic [15:0] m_writedata [2];
   logic        m_strobe    [2];
   logic        m_write     [2];
   logic        m_cycle     [2];
   logic [15:0] m0_readdata;
   logic [15:0] m1_readdata;
   logic        m0_ack;
   logic        m0_err;
   logic        m1_ack;
   logic        m1_err;
   logic [0:0]  s_address;
   logic [15:0] s_writedata;
   logic [15:0] s_readdata;
   logic        s_strobe;
   logic        s_write;
   logic        s_cycle;
   logic        s_ack;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   // Reference model: -1 means nobody owns the bus.
   int model_owner = -1;
   int model_last  = 1;
   int model_wait  = 0;

   leds_wb_arbiter #(
      .ADDR_WIDTH(1),
      .DATA_WIDTH(16),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .m0_address(m_address[0]),
      .m0_writedata(m_writedata[0]),
      .m0_readdata(m0_readdata),
      .m0_strobe(m_strobe[0]),
      .m0_write(m_write[0]),
      .m0_cycle(m_cycle[0]),
      .m0_ack(m0_ack),
      .m0_err(m0_err),
      .m1_address(m_address[1]),
      .m1_writedata(m_writedata[1]),
      .m1_readdata(m1_readdata),
      .m1_strobe(m_strobe[1]),
      .m1_write(m_write[1]),
      .m1_cycle(m_cycle[1]),
      .m1_ack(m1_ack),
      .m1_err(m1_err),
      .s_address(s_address),
      .s_writedata(s_writedata),
      .s_readdata(s_readdata),
      .s_strobe(s_strobe),
      .s_write(s_write),
      .s_cycle(s_cycle),
      .s_ack(s_ack),
      .grant(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic c0, input logic s0, input logic w0,
                                input logic c1, input logic s1, input logic w1, input logic ack);
      m_cycle[0]  = c0;
      m_strobe[0] = s0;
      m_write[0]  = w0;
      m_cycle[1]  = c1;
      m_strobe[1] = s1;
      m_write[1]  = w1;
      s_ack       = ack;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Model update: who owns the bus after this edge, and how long the owner has waited for ack.
   always @(posedge clk) begin
      if (reset) begin
         model_owner <= -1;
         model_last  <= 1;
         model_wait  <= 0;
      end else if (model_owner < 0) begin
         model_wait <= 0;
         if (m_cycle[0] && m_cycle[1]) model_owner <= 1 - model_last;
         else if (m_cycle[0])          model_owner <= 0;
         else if (m_cycle[1])          model_owner <= 1;
      end else if ((model_wait == TMO && !s_ack) || !m_cycle[model_owner]) begin
         model_last  <= model_owner;
         model_owner <= -1;
         model_wait  <= 0;
      end else if (m_strobe[model_owner] && !s_ack) begin
         model_wait <= model_wait + 1;
      end else begin
         model_wait <= 0;
      end
   end

   logic [1:0]  exp_grant;
   logic        exp_scyc, exp_sstb, exp_swe, exp_tmo;
   logic [0:0]  exp_saddr;
   logic [15:0] exp_swdata;
   logic        exp_ack [2];
   logic        exp_err [2];

   // Every non-reset cycle: derive the expected outputs from the model and compare them all.
   always @(negedge clk) begin
      if (!reset) begin
         exp_grant  = 2'b00;
         exp_scyc   = 1'b0;
         exp_sstb   = 1'b0;
         exp_swe    = 1'b0;
         exp_saddr  = '0;
         exp_swdata = '0;
         exp_ack[0] = 1'b0;
         exp_ack[1] = 1'b0;
         exp_err[0] = 1'b0;
         exp_err[1] = 1'b0;
         if (model_owner >= 0) begin
            exp_tmo                 = (model_wait == TMO) && !s_ack;
            exp_grant               = (model_owner == 1) ? 2'b10 : 2'b01;
            exp_scyc                = m_cycle[model_owner] && !exp_tmo;
            exp_sstb                = m_strobe[model_owner] && !exp_tmo;
            exp_swe                 = m_write[model_owner];
            exp_saddr               = m_address[model_owner];
            exp_swdata              = m_writedata[model_owner];
            exp_ack[model_owner]    = s_ack;
            exp_err[model_owner]    = exp_tmo;
         end
         checkOutput("model grant", 32'(grant), 32'(exp_grant));
         checkOutput("model s_cycle", 32'(s_cycle), 32'(exp_scyc));
         checkOutput("model s_strobe", 32'(s_strobe), 32'(exp_sstb));
         checkOutput("model s_write", 32'(s_write), 32'(exp_swe));
         checkOutput("model s_address", 32'(s_address), 32'(exp_saddr));
         checkOutput("model s_writedata", 32'(s_writedata), 32'(exp_swdata));
         checkOutput("model m0_ack", 32'(m0_ack), 32'(exp_ack[0]));
         checkOutput("model m1_ack", 32'(m1_ack), 32'(exp_ack[1]));
         checkOutput("model m0_err", 32'(m0_err), 32'(exp_err[0]));
         checkOutput("model m1_err", 32'(m1_err), 32'(exp_err[1]));
         checkOutput("model m0_readdata", 32'(m0_readdata), 32'(s_readdata));
         checkOutput("model m1_readdata", 32'(m1_readdata), 32'(s_readdata));
      end
   end

   initial begin
      reset          = 1'b1;
      m_address[0]   = '0;
      m_address[1]   = '0;
      m_writedata[0] = '0;
      m_writedata[1] = '0;
      s_readdata     = 16'h5A5A;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      step();
      reset = 1'b0;
      settle();
      checkOutput("reset grant", 32'(grant), 32'h0);
      checkOutput("reset s_cycle", 32'(s_cycle), 32'h0);
      checkOutput("reset m0_ack", 32'(m0_ack), 32'h0);
      checkOutput("reset m0_err", 32'(m0_err), 32'h0);

      $display("[TB] single master write");
      step();
      m_address[0]   = 1'b1;
      m_writedata[0] = 16'h000A;
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      settle();
      checkOutput("write latency grant", 32'(grant), 32'h0);
      step();
      applyStimulus(1, 1, 1, 0, 0, 0, 1);
      settle();
      checkOutput("write grant", 32'(grant), 32'h1);
      checkOutput("write s_writedata", 32'(s_writedata), 32'h000A);
      checkOutput("write s_address", 32'(s_address), 32'h1);
      checkOutput("write m0_ack", 32'(m0_ack), 32'h1);
      checkOutput("write readdata", 32'(m0_readdata), 32'h5A5A);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("write ack pulse", 32'(m0_ack), 32'h0);
      step();
      settle();
      checkOutput("write release grant", 32'(grant), 32'h0);

      $display("[TB] tie and alternation");
      step();
      reset = 1'b1;
      settle();
      step();
      reset = 1'b0;
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      settle();
      checkOutput("tie idle grant", 32'(grant), 32'h0);
      step();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      settle();
      checkOutput("tie first grant", 32'(grant), 32'h1);
      step();
      settle();
      checkOutput("tie gap grant", 32'(grant), 32'h0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("tie second grant", 32'(grant), 32'h2);
      step();
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      settle();
      checkOutput("tie gap2 grant", 32'(grant), 32'h0);
      step();
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      settle();
      checkOutput("tie repeat grant", 32'(grant), 32'h1);

      $display("[TB] no preemption");
      step();
      settle();
      checkOutput("preempt gap grant", 32'(grant), 32'h0);
      step();
      applyStimulus(1, 0, 0, 1, 1, 1, 1);
      settle();
      checkOutput("preempt m1 grant", 32'(grant), 32'h2);
      checkOutput("preempt m1_ack", 32'(m1_ack), 32'h1);
      checkOutput("preempt m0_ack", 32'(m0_ack), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         settle();
         checkOutput("preempt hold grant", 32'(grant), 32'h2);
         checkOutput("preempt hold m0_ack", 32'(m0_ack), 32'h0);
      end
      step();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("preempt drop grant", 32'(grant), 32'h2);
      step();
      settle();
      checkOutput("preempt idle grant", 32'(grant), 32'h0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("preempt m0 grant", 32'(grant), 32'h1);

      $display("[TB] watchdog timeout");
      step();
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      settle();
      checkOutput("timeout idle grant", 32'(grant), 32'h0);
      for (int i = 0; i <= TMO; i++) begin
         step();
         if (i == TMO) m_cycle[1] = 1'b1;
         settle();
         checkOutput("timeout m0_err", 32'(m0_err), (i == TMO) ? 32'h1 : 32'h0);
         checkOutput("timeout s_cycle", 32'(s_cycle), (i == TMO) ? 32'h0 : 32'h1);
         checkOutput("timeout s_strobe", 32'(s_strobe), (i == TMO) ? 32'h0 : 32'h1);
         checkOutput("timeout m0_ack", 32'(m0_ack), 32'h0);
      end
      step();
      settle();
      checkOutput("timeout release grant", 32'(grant), 32'h0);
      checkOutput("timeout err pulse", 32'(m0_err), 32'h0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("timeout m1 grant", 32'(grant), 32'h2);

      $display("[TB] ack versus timeout race");
      step();
      applyStimulus(1, 1, 0, 0, 0, 0, 0);
      settle();
      checkOutput("race idle grant", 32'(grant), 32'h0);
      for (int i = 0; i <= TMO; i++) begin
         step();
         if (i == TMO) s_ack = 1'b1;
         settle();
      end
      checkOutput("race m0_ack", 32'(m0_ack), 32'h1);
      checkOutput("race m0_err", 32'(m0_err), 32'h0);
      checkOutput("race s_cycle", 32'(s_cycle), 32'h1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      settle();
      checkOutput("race kept grant", 32'(grant), 32'h1);

      $display("[TB] reset mid-transfer");
      step();
      applyStimulus(0, 0, 0, 1, 1, 0, 0);
      settle();
      checkOutput("midreset idle grant", 32'(grant), 32'h0);
      step();
      settle();
      checkOutput("midreset m1 grant", 32'(grant), 32'h2);
      checkOutput("midreset s_strobe", 32'(s_strobe), 32'h1);
      step();
      reset = 1'b1;
      settle();
      checkOutput("midreset m1_ack", 32'(m1_ack), 32'h0);
      checkOutput("midreset m1_err", 32'(m1_err), 32'h0);
      step();
      reset = 1'b0;
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      settle();
      checkOutput("midreset after grant", 32'(grant), 32'h0);
      checkOutput("midreset after s_cycle", 32'(s_cycle), 32'h0);
      checkOutput("midreset after s_strobe", 32'(s_strobe), 32'h0);
      checkOutput("midreset after m1_ack", 32'(m1_ack), 32'h0);
      checkOutput("midreset after m1_err", 32'(m1_err), 32'h0);
      step();
      settle();
      checkOutput("midreset tie grant", 32'(grant), 32'h1);

      $display("[TB] random traffic");
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         step();
         reset = ($urandom_range(0, 199) == 0);
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 7) == 0) m_cycle[k] = ~m_cycle[k];
            m_strobe[k]    = m_cycle[k] && ($urandom_range(0, 3) != 0);
            m_write[k]     = 1'($urandom_range(0, 1));
            m_address[k]   = 1'($urandom_range(0, 1));
            m_writedata[k] = 16'($urandom);
         end
         s_ack      = ($urandom_range(0, 4) == 0);
         s_readdata = 16'($urandom);
      end
      step();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
